dma_desc_splitter: RTL and testbench



---
 rtl/dma_desc_splitter_if.sv | 66 ++++++
 rtl/dma_desc_splitter.sv | 198 +++++++++++++++++++
 tb/tb_dma_desc_splitter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_desc_splitter_if.sv
// Command, descriptor and status signals of the DMA descriptor splitter.
// slave = the splitter itself, master = the command/engine side.
interface dma_desc_splitter_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [63:0]  cmd_sys_addr;
    logic [63:0]  cmd_card_addr;
    logic [31:0]  cmd_bcount;
    logic         abort_req;

    logic         desc_req;
    logic         desc_ready;
    logic [31:0]  desc_ptr;
    logic [255:0] desc_data;
    logic         desc_abort;
    logic         desc_abort_ack;
    logic         desc_done;
    logic [159:0] desc_done_status;

    logic         sts_valid;
    logic [159:0] sts_data;
    logic         sts_err;
    logic         sts_aborted;

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_sys_addr,
        input  cmd_card_addr,
        input  cmd_bcount,
        input  abort_req,
        output desc_req,
        input  desc_ready,
        output desc_ptr,
        output desc_data,
        output desc_abort,
        input  desc_abort_ack,
        input  desc_done,
        input  desc_done_status,
        output sts_valid,
        output sts_data,
        output sts_err,
        output sts_aborted
    );

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_sys_addr,
        output cmd_card_addr,
        output cmd_bcount,
        output abort_req,
        input  desc_req,
        output desc_ready,
        input  desc_ptr,
        input  desc_data,
        input  desc_abort,
        output desc_abort_ack,
        output desc_done,
        output desc_done_status,
        input  sts_valid,
        input  sts_data,
        input  sts_err,
        input  sts_aborted
    );
endinterface

// File: rtl/dma_desc_splitter.sv
// Splits a DMA command into block-mode descriptors that never cross a
// 2^DMA_REMAIN system-address boundary, tracks completions, reports status.
module dma_desc_splitter #(
    parameter int DMA_REMAIN   = 12,
    parameter int WAIT_DONE_EN = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    dma_desc_splitter_if.slave  bus
);

    localparam logic [31:0] DMA_BYTES = 32'(1) << DMA_REMAIN;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT_LOW,
        WAIT_DONE,
        ABORT,
        REPORT
    } state_t;

    state_t         state_q;
    logic [63:0]    sys_q;
    logic [63:0]    card_q;
    logic [31:0]    remain_q;
    logic [31:0]    xfer_q;
    logic [31:0]    num_desc_q;
    logic [31:0]    num_done_q;
    logic [31:0]    done_bcount_q;
    logic [159:0]   status_q;
    logic           err_q;
    logic           aborted_q;

    logic           cmd_ready_q;
    logic           desc_req_q;
    logic           desc_abort_q;
    logic [255:0]   desc_data_q;
    logic           sts_valid_q;
    logic           sts_err_q;
    logic           sts_aborted_q;
    logic [159:0]   sts_data_q;

    logic [31:0]    offset_d;
    logic [31:0]    room_d;
    logic [31:0]    xfer_d;
    logic           first_d;
    logic           last_d;
    logic           done_hit;
    logic           abort_hit;
    logic [31:0]    num_done_d;
    logic [31:0]    done_bcount_d;
    logic [159:0]   status_d;

    assign offset_d = {{(32-DMA_REMAIN){1'b0}}, sys_q[DMA_REMAIN-1:0]};
    assign room_d   = DMA_BYTES - offset_d;

    always_comb begin
        xfer_d  = (remain_q < room_d) ? remain_q : room_d;
        first_d = (num_desc_q == 32'd0);
        last_d  = (xfer_d == remain_q);
    end

    // Completions count in every active state, even on an accept edge.
    assign done_hit  = bus.desc_done && (state_q != IDLE);
    assign abort_hit = bus.abort_req
                     && (state_q != IDLE)
                     && (state_q != REPORT)
                     && (state_q != ABORT);

    always_comb begin
        num_done_d    = num_done_q;
        done_bcount_d = done_bcount_q;
        status_d      = status_q;
        if (done_hit) begin
            num_done_d    = num_done_q + 32'd1;
            done_bcount_d = done_bcount_q + bus.desc_done_status[63:32];
            status_d      = bus.desc_done_status;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sys_q         <= '0;
            card_q        <= '0;
            remain_q      <= '0;
            xfer_q        <= '0;
            num_desc_q    <= '0;
            num_done_q    <= '0;
            done_bcount_q <= '0;
            status_q      <= '0;
            err_q         <= 1'b0;
            aborted_q     <= 1'b0;
            cmd_ready_q   <= 1'b1;
            desc_req_q    <= 1'b0;
            desc_abort_q  <= 1'b0;
            desc_data_q   <= '0;
            sts_valid_q   <= 1'b0;
            sts_err_q     <= 1'b0;
            sts_aborted_q <= 1'b0;
            sts_data_q    <= '0;
        end else begin
            sts_valid_q   <= 1'b0;
            num_done_q    <= num_done_d;
            done_bcount_q <= done_bcount_d;
            status_q      <= status_d;
            if (abort_hit) begin
                desc_req_q   <= 1'b0;
                desc_abort_q <= 1'b1;
                state_q      <= ABORT;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.cmd_valid && cmd_ready_q) begin
                            cmd_ready_q   <= 1'b0;
                            sys_q         <= bus.cmd_sys_addr;
                            card_q        <= bus.cmd_card_addr;
                            remain_q      <= bus.cmd_bcount;
                            num_desc_q    <= '0;
                            num_done_q    <= '0;
                            done_bcount_q <= '0;
                            aborted_q     <= 1'b0;
                            err_q         <= (bus.cmd_bcount == 32'd0);
                            state_q       <= (bus.cmd_bcount == 32'd0)
                                             ? REPORT : CALC;
                        end
                    end
                    CALC: begin
                        xfer_q      <= xfer_d;
                        desc_data_q <= {64'd0, card_q, sys_q, xfer_d,
                                        20'd0, last_d, first_d,
                                        9'd0, last_d};
                        desc_req_q  <= 1'b1;
                        state_q     <= ISSUE;
                    end
                    ISSUE: begin
                        if (bus.desc_ready) begin
                            desc_req_q <= 1'b0;
                            sys_q      <= sys_q + {32'd0, xfer_q};
                            card_q     <= card_q + {32'd0, xfer_q};
                            remain_q   <= remain_q - xfer_q;
                            num_desc_q <= num_desc_q + 32'd1;
                            state_q    <= WAIT_LOW;
                        end
                    end
                    WAIT_LOW: begin
                        if (!bus.desc_ready) begin
                            if (remain_q != 32'd0)
                                state_q <= CALC;
                            else if (WAIT_DONE_EN != 0)
                                state_q <= WAIT_DONE;
                            else
                                state_q <= REPORT;
                        end
                    end
                    WAIT_DONE: begin
                        if ((num_done_q >= num_desc_q) && (remain_q == 32'd0))
                            state_q <= REPORT;
                    end
                    ABORT: begin
                        if (bus.desc_abort_ack) begin
                            desc_abort_q <= 1'b0;
                            aborted_q    <= 1'b1;
                            state_q      <= REPORT;
                        end
                    end
                    REPORT: begin
                        sts_valid_q   <= 1'b1;
                        sts_err_q     <= err_q;
                        sts_aborted_q <= aborted_q;
                        // Include a completion landing on this very edge.
                        if (WAIT_DONE_EN != 0)
                            sts_data_q <= {status_d[159:64], done_bcount_d,
                                           status_d[31:0]};
                        else
                            sts_data_q <= '0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.desc_req    = desc_req_q;
    assign bus.desc_ptr    = 32'd0;
    assign bus.desc_data   = desc_data_q;
    assign bus.desc_abort  = desc_abort_q;
    assign bus.sts_valid   = sts_valid_q;
    assign bus.sts_data    = sts_data_q;
    assign bus.sts_err     = sts_err_q;
    assign bus.sts_aborted = sts_aborted_q;

endmodule

// File: tb/tb_dma_desc_splitter.sv
// Random commands against a queue-based model of descriptor splitting
// and completion accounting, plus directed abort/reset scenarios.
module tb_dma_desc_splitter;

    localparam int          DMA_REMAIN = 12;
    localparam int unsigned DMA_BYTES  = 1 << DMA_REMAIN;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dma_desc_splitter_if bus();

    dma_desc_splitter #(
        .DMA_REMAIN(DMA_REMAIN),
        .WAIT_DONE_EN(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int           n_vec = 0;
    int           n_err = 0;
    logic [159:0] last_sts;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cmd_valid        = 1'b0;
        bus.cmd_sys_addr     = '0;
        bus.cmd_card_addr    = '0;
        bus.cmd_bcount       = '0;
        bus.abort_req        = 1'b0;
        bus.desc_ready       = 1'b0;
        bus.desc_abort_ack   = 1'b0;
        bus.desc_done        = 1'b0;
        bus.desc_done_status = '0;
    endtask

    task automatic chk_reset_state();
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_desc_req", bus.desc_req, 1'b0);
        chk("rst_desc_abort", bus.desc_abort, 1'b0);
        chk("rst_sts_valid", bus.sts_valid, 1'b0);
        chk("rst_sts_err", bus.sts_err, 1'b0);
        chk("rst_sts_aborted", bus.sts_aborted, 1'b0);
        chk("rst_desc_data", bus.desc_data, '0);
        chk("rst_sts_data", bus.sts_data, '0);
        chk("rst_desc_ptr", bus.desc_ptr, '0);
    endtask

    // mode 0: random engine; 1: abort in WAIT_DONE; 2: dones on accept
    // edges; 3: stop with the second descriptor pending in ISSUE.
    task automatic run_cmd(input logic [63:0] sys, input logic [63:0] card,
                           input logic [31:0] bc, input int mode);
        logic [255:0] exp_q[$];
        logic [31:0]  xf_all[$];
        logic [31:0]  xf_q[$];
        logic [63:0]  s, c;
        logic [31:0]  rem, room, x, sum;
        logic [159:0] st;
        bit           first, lst, acc, acc_prev, dn, got_first, finished;
        int           k, n_acc, n_exp, n_dl, wait_cnt, ab_cnt;

        s = sys;
        c = card;
        rem = bc;
        first = 1'b1;
        while (rem != 0) begin
            room = DMA_BYTES - (s[31:0] % DMA_BYTES);
            x = (rem < room) ? rem : room;
            lst = (x == rem);
            exp_q.push_back({64'd0, c, s, x, 20'd0, lst, first, 9'd0, lst});
            xf_all.push_back(x);
            s += {32'd0, x};
            c += {32'd0, x};
            rem -= x;
            first = 1'b0;
        end
        n_exp = exp_q.size();

        bus.cmd_sys_addr  = sys;
        bus.cmd_card_addr = card;
        bus.cmd_bcount    = bc;
        bus.cmd_valid     = 1'b1;
        chk("cmd_ready", bus.cmd_ready, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;

        sum = 0; n_acc = 0; n_dl = 0; k = 0;
        acc_prev = 0; got_first = 0; finished = 0;
        wait_cnt = 0; ab_cnt = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            k++;
            if (acc_prev) chk("req_drop", bus.desc_req, 1'b0);
            if (bus.desc_req) begin
                if (n_acc < n_exp) begin
                    if (!got_first) begin
                        chk("req_latency", k, 2);
                        got_first = 1'b1;
                    end
                    chk("desc_data", bus.desc_data, exp_q[n_acc]);
                end else begin
                    chk("extra_desc", bus.desc_req, 1'b0);
                end
            end
            if (bus.desc_abort) begin
                ab_cnt++;
                chk("abort_req_low", bus.desc_req, 1'b0);
            end
            if (bus.sts_valid) begin
                if (bc == 0) chk("err_latency", k, 2);
                chk("sts_err", bus.sts_err, bc == 0);
                chk("sts_aborted", bus.sts_aborted, mode == 1);
                chk("sts_data", bus.sts_data,
                    {last_sts[159:64], sum, last_sts[31:0]});
                if (mode == 1) chk("abort_len", ab_cnt, 5);
                else           chk("n_desc", n_acc, n_exp);
                finished = 1'b1;
            end else if (mode == 3 && n_acc == 1 && bus.desc_req) begin
                bus.desc_ready = 1'b0;
                bus.desc_done  = 1'b0;
                finished = 1'b1;
            end else begin
                bus.abort_req      = 1'b0;
                bus.desc_abort_ack = 1'b0;
                bus.desc_done      = 1'b0;
                bus.desc_ready     = ($urandom % 2) == 1;
                if (mode == 1 && n_acc == n_exp) begin
                    bus.desc_ready = 1'b0;
                    wait_cnt++;
                    if (wait_cnt == 3) bus.abort_req = 1'b1;
                end
                if (bus.desc_abort && ab_cnt == 5) bus.desc_abort_ack = 1'b1;
                acc = bus.desc_req && bus.desc_ready;
                dn = 1'b0;
                if (xf_q.size() > 0) begin
                    case (mode)
                        1: dn = (n_dl < n_exp - 1) && (($urandom % 2) == 1);
                        2: dn = acc || (n_acc == n_exp);
                        default: dn = ($urandom % 3) == 0;
                    endcase
                end
                if (dn) begin
                    st = {$urandom, $urandom, $urandom, xf_q[0], $urandom};
                    bus.desc_done = 1'b1;
                    bus.desc_done_status = st;
                end
                tick();
                if (dn) begin
                    sum += xf_q.pop_front();
                    last_sts = st;
                    n_dl++;
                end
                if (acc) begin
                    xf_q.push_back(xf_all[n_acc]);
                    n_acc++;
                end
                acc_prev = acc;
            end
        end
        chk("finished", finished, 1'b1);
        if (mode != 3) begin
            clear_inputs();
            tick();
            chk("sts_pulse", bus.sts_valid, 1'b0);
            chk("idle_ready", bus.cmd_ready, 1'b1);
        end
    endtask

    initial begin
        logic [63:0] rs, rc;
        logic [31:0] rb;
        rst_n = 1'b0;
        last_sts = '0;
        clear_inputs();
        repeat (3) tick();
        chk_reset_state();
        rst_n = 1'b1;
        tick();

        run_cmd(64'h1000, 64'h0, 32'h100, 0);
        run_cmd(64'h0F00, 64'h8000, 32'h1200, 0);
        run_cmd(64'h1234, 64'h5678, 32'h0, 0);
        run_cmd(64'h0F00, 64'h8000, 32'h1200, 1);
        run_cmd(64'h0F00, 64'h8000, 32'h1200, 2);

        run_cmd(64'h0F00, 64'h8000, 32'h1200, 3);
        rst_n = 1'b0;
        tick();
        chk_reset_state();
        rst_n = 1'b1;
        last_sts = '0;
        for (int i = 0; i < 8; i++) begin
            bus.desc_done = ($urandom % 2) == 1;
            bus.desc_done_status = {$urandom, $urandom, $urandom,
                                    $urandom, $urandom};
            tick();
            chk("post_rst_sts", bus.sts_valid, 1'b0);
            chk("post_rst_req", bus.desc_req, 1'b0);
        end
        clear_inputs();
        tick();

        for (int i = 0; i < 30; i++) begin
            rs = {$urandom, $urandom};
            if ((i % 4) == 0) rs[11:0] = '0;
            rc = {$urandom, $urandom};
            rb = (($urandom % 6) == 0) ? 32'd0 : $urandom_range(32'h3000, 1);
            run_cmd(rs, rc, rb, ((i % 5) == 4) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
